gpio_sel_mask_ctrl: RTL

Parametrised, registered successor to the combinational GPIO index decoder. Accepts pin-select commands over a valid/ready handshake and decodes a 1-based pin index into a NUM_PINS-wide pin mask. The mask is updated by one of four modes (replace/set/clear/toggle), and a settle guard follows every update. It sits between a team-project control FSM and the GPIO output-enable and select fabric.

---
 rtl/gpio_sel_mask_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/gpio_sel_mask_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_sel_mask_ctrl
//
// Registered GPIO pin-select controller. A command carries a 1-based pin
// index and an update mode. The index is decoded to a one-hot pin mask, which
// then modifies the held mask_out register using one of four modes:
// replace, set, clear or toggle. After every update the block stays busy for
// SETTLE_CYCLES cycles before it accepts the next command.
//
// Index 0 and indices above NUM_PINS decode to an all-zero one-hot. As a
// result, REPLACE clears the mask, and SET/CLEAR/TOGGLE leave it unchanged.
// This matches the legacy combinational decoder, which output all zeros for
// such indices.
//
// Ports
//   clk           in   system clock, rising edge
//   nrst          in   asynchronous active-low reset
//   cmd_valid     in   command present
//   cmd_ready     out  block can accept a command (decoded from state only)
//   cmd_idx       in   1-based pin index, 0 = no pin
//   cmd_mode      in   0=REPLACE 1=SET 2=CLEAR 3=TOGGLE
//   mask_out      out  registered pin mask, bit n <-> index n+1
//   busy          out  high while applying or settling
//   update_pulse  out  one-cycle pulse in the cycle after mask_out is written
//   err_oob       out  sticky: an accepted index exceeded NUM_PINS
//   err_clr       in   synchronous clear of err_oob (a new error wins)
// ---------------------------------------------------------------------------
module gpio_sel_mask_ctrl #(
    parameter int                  NUM_PINS      = 34,
    parameter int                  IDX_W         = 6,
    parameter int                  SETTLE_CYCLES = 2,
    parameter logic [NUM_PINS-1:0] RESET_MASK    = '0
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IDX_W-1:0]    cmd_idx,
    input  logic [1:0]          cmd_mode,
    output logic [NUM_PINS-1:0] mask_out,
    output logic                busy,
    output logic                update_pulse,
    output logic                err_oob,
    input  logic                err_clr
);

    // The settle counter only has to hold SETTLE_CYCLES-1.
    localparam int CNT_W       = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] SETTLE_LOAD_C = CNT_W'(SETTLE_LOAD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_REPLACE = 2'd0,
        MODE_SET     = 2'd1,
        MODE_CLEAR   = 2'd2,
        MODE_TOGGLE  = 2'd3
    } mode_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    mode_e               mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_PINS-1:0] mask_q, mask_d;
    logic                pulse_q, pulse_d;
    logic                err_q, err_d;

    logic                accept;
    logic [NUM_PINS-1:0] onehot;
    logic                idx_oob;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state is written only with non-blocking assignments.
    // Blocking assignments here would let other always_ff blocks read the new
    // value in the same edge, and the result would depend on process order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: each combinational block assigns its outputs a default first.
    // Without the default, a path through the case that leaves a signal
    // unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_IDLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs decoded from the state register alone, so there is no
    // combinational path from cmd_valid to cmd_ready.
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE:   cmd_ready = 1'b1;
            ST_APPLY:  busy      = 1'b1;
            ST_SETTLE: busy      = 1'b1;
            default: begin
                cmd_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign accept = cmd_valid && cmd_ready;

    // -----------------------------------------------------------------------
    // Command capture. Index and mode are sampled only at the accept edge.
    // Changes on the inputs while busy have no effect.
    // -----------------------------------------------------------------------
    always_comb begin
        idx_d  = idx_q;
        mode_d = mode_q;
        if (accept) begin
            idx_d  = cmd_idx;
            mode_d = mode_e'(cmd_mode);
        end
    end

    // -----------------------------------------------------------------------
    // Settle counter. It loads at the APPLY edge and then counts down once
    // per SETTLE cycle. The FSM leaves SETTLE in the cycle where the counter
    // reads zero, so SETTLE lasts exactly SETTLE_CYCLES cycles.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_APPLY) begin
            cnt_d = SETTLE_LOAD_C;
        end else if (state_q == ST_SETTLE && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Index decode. The index is compared as a plain integer so that an index
    // above NUM_PINS cannot wrap onto a low pin. Index 0 matches no bit.
    // -----------------------------------------------------------------------
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            onehot[i] = (int'(idx_q) == i + 1);
        end
    end

    assign idx_oob = (int'(idx_q) > NUM_PINS);

    // -----------------------------------------------------------------------
    // Mask update, performed in APPLY only. An empty one-hot makes
    // SET/CLEAR/TOGGLE no-ops and makes REPLACE clear the mask.
    // -----------------------------------------------------------------------
    always_comb begin
        mask_d = mask_q;
        if (state_q == ST_APPLY) begin
            case (mode_q)
                MODE_REPLACE: mask_d = onehot;
                MODE_SET:     mask_d = mask_q | onehot;
                MODE_CLEAR:   mask_d = mask_q & ~onehot;
                MODE_TOGGLE:  mask_d = mask_q ^ onehot;
                default:      mask_d = mask_q;
            endcase
        end
    end

    // update_pulse is registered at the same edge as the mask write. It is
    // therefore high during the cycle that follows the write.
    always_comb begin
        pulse_d = (state_q == ST_APPLY);
    end

    // A new out-of-range error takes priority over a clear in the same cycle.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_APPLY && idx_oob) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q   <= '0;
            mode_q  <= MODE_REPLACE;
            cnt_q   <= '0;
            mask_q  <= RESET_MASK;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign mask_out     = mask_q;
    assign update_pulse = pulse_q;
    assign err_oob      = err_q;

endmodule
